fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
Parametrised instruction-fetch and PC sequencer for the riscv32 core family, generalising the single-cycle PC/ROM path.
- Supports configurable address width and reset vector.
- Tolerates ROM wait states through a valid handshake.
- Delivers instructions to decode with a valid/ready handshake.
- Accepts branch/jump redirects at any point, including while a ROM access is in flight.
- Sits between the instruction ROM and the decode/ALU stage.
- Exposes cycle and retired-fetch counters for bench reporting.

Parameters:
ADDR_W, 8, byte-address width of PC (>=3); ROM word address is ADDR_W-2 bits
XLEN, 32, instruction width
RESET_PC, 0, PC value after reset (must be 4-byte aligned)
CNT_W, 32, width of cycle and fetch counters

Ports:
iCLK  in  1  clock
iRST_N  in  1  reset, asynchronous assert, active-low
oROM_CE  out  1  ROM chip enable; high while an access is outstanding
oROM_RD  out  1  ROM read strobe; equals oROM_CE
oROM_ADDR  out  ADDR_W-2  word address (PC[ADDR_W-1:2]); stable while oROM_CE high
iROM_DATA  in  XLEN  ROM read data; valid when iROM_VALID high
iROM_VALID  in  1  ROM response strobe for the current oROM_ADDR
oIR  out  XLEN  held instruction
oIR_PC  out  ADDR_W  byte PC of oIR
oIR_VALID  out  1  oIR/oIR_PC valid
iIR_READY  in  1  decode accepts oIR this cycle
iBR_TAKEN  in  1  redirect request (branch, JAL, JALR)
iBR_TARGET  in  ADDR_W  redirect byte address
oMISALIGN  out  1  sticky: a redirect target had bits [1:0] != 0
oCYCLE  out  CNT_W  cycles since reset release
oFETCH_CNT  out  CNT_W  instructions accepted by decode

Behaviour:
- Reset (iRST_N low, async): state FETCH, PC=RESET_PC. All outputs and counters are 0 except oROM_CE/oROM_RD, which follow the state after reset release. oIR, oIR_PC, oIR_VALID and oMISALIGN are 0.
- States:
  - FETCH: CE high, address=PC. If iROM_VALID, latch oIR=iROM_DATA and oIR_PC=PC, then go to HOLD; otherwise go to WAIT.
  - WAIT: CE high, address held. On iROM_VALID, latch as in FETCH and go to HOLD.
  - HOLD: CE low, oIR_VALID high.
    - On iIR_READY: PC <= PC+4 (mod 2^ADDR_W, wraps silently), oFETCH_CNT++, go to FETCH.
  - KILL: CE high, address held (old PC). On iROM_VALID, discard the data and go to FETCH. PC already holds the target.
- Zero-wait ROM: one instruction every 2 cycles (FETCH, HOLD). Latency from FETCH entry to oIR_VALID is 1 cycle plus wait states.
- oIR_VALID deasserts the cycle after acceptance. oIR is stable while oIR_VALID is high and iIR_READY is low.
- Redirect (iBR_TAKEN high), sampled every cycle; it has priority over sequential PC update:
  - Target alignment: PC <= {iBR_TARGET[ADDR_W-1:2], 2'b00}. If iBR_TARGET[1:0] != 0, set oMISALIGN (sticky until reset).
  - HOLD with iIR_READY: the instruction counts as accepted (oFETCH_CNT++); next state FETCH at target.
  - HOLD without iIR_READY: the held instruction is dropped (oIR_VALID low next cycle, not counted); next state FETCH.
  - FETCH/WAIT with iROM_VALID the same cycle: the response is discarded; next state FETCH at target.
  - FETCH/WAIT without iROM_VALID: next state KILL. The access in flight completes at the old address before the target is issued.
  - KILL: PC is overwritten by the newest target and the state remains KILL.
- oCYCLE increments every cycle out of reset and wraps. oFETCH_CNT wraps.
- Reset mid-access: the outstanding ROM response is ignored; fetch restarts at RESET_PC.

Decomposition:
- Shared package/header `rv_fetch_defs`:
  - state encodings: FETCH=2'd0, WAIT=2'd1, HOLD=2'd2, KILL=2'd3
  - ILEN_BYTES=4
  - RV opcode constants: BRANCH 1100011, JAL 1101111, JALR 1100111, used by benches
- One sub-module, `fetch_counters` (oCYCLE, oFETCH_CNT), parametrised by CNT_W with an increment-enable input.
- The FSM and PC register stay in fetch_sequencer.

Test Plan:
- Zero-wait ROM (iROM_VALID tied high), iIR_READY=1, RESET_PC=0 -> oIR_PC sequence 0x00,0x04,0x08 on alternate cycles; oFETCH_CNT=3 after 6 cycles.
- ROM with 3 wait states, iIR_READY held low 4 cycles in HOLD -> oIR stable throughout; oROM_CE low during HOLD; next oROM_ADDR=1.
- In HOLD at PC 0x10: iBR_TAKEN=1, iBR_TARGET=0x40, iIR_READY=0 -> instruction dropped, oFETCH_CNT unchanged, next oROM_ADDR=0x10 (word).
- Redirect to 0x20 in WAIT at PC 0x08 with 2 remaining wait states -> state KILL; data at word 2 discarded; next oIR_PC=0x20, never 0x08.
- ADDR_W=8, PC=0xFC accepted -> next oROM_ADDR=0 (wrap). iBR_TARGET=0x42 -> PC=0x40, oMISALIGN=1 until iRST_N low.
- iRST_N pulsed low mid-WAIT -> outputs clear immediately (async); after release, fetch at RESET_PC; the late iROM_VALID is ignored.

Source files
------------

// File: rtl/rv_fetch_defs_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
// Holds the sequencer state encoding, the instruction length in bytes and
// the RV32 opcodes of the control-transfer instructions that cause redirects.
package rv_fetch_defs;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,  // issue ROM access at PC
    ST_WAIT  = 2'd1,  // ROM access outstanding, address held
    ST_HOLD  = 2'd2,  // instruction presented to decode
    ST_KILL  = 2'd3   // draining a stale access after a redirect
  } fetch_state_t;

  localparam int ILEN_BYTES = 4;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

endpackage

// File: rtl/fetch_counters.sv
// Free-running cycle counter and accepted-instruction counter.
// Ports:
//   clk       - clock
//   rst_n     - asynchronous active-low reset
//   fetch_inc - one instruction accepted by decode this cycle
//   cycle     - cycles since reset release (wraps)
//   fetch_cnt - instructions accepted since reset (wraps)
module fetch_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_inc,
  output logic [CNT_W-1:0] cycle,
  output logic [CNT_W-1:0] fetch_cnt
);

  logic [CNT_W-1:0] cycle_reg;
  logic [CNT_W-1:0] fetch_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_reg     <= '0;
      fetch_cnt_reg <= '0;
    end else begin
      cycle_reg <= cycle_reg + 1'b1;
      if (fetch_inc) begin
        fetch_cnt_reg <= fetch_cnt_reg + 1'b1;
      end
    end
  end

  assign cycle     = cycle_reg;
  assign fetch_cnt = fetch_cnt_reg;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch / PC sequencer between the instruction ROM and decode.
// Ports:
//   iCLK, iRST_N                   - clock, async active-low reset
//   oROM_CE/oROM_RD/oROM_ADDR      - ROM request (word address, held while CE)
//   iROM_DATA/iROM_VALID           - ROM response
//   oIR/oIR_PC/oIR_VALID/iIR_READY - instruction handshake towards decode
//   iBR_TAKEN/iBR_TARGET           - redirect request (byte address)
//   oMISALIGN                      - sticky flag for unaligned redirect targets
//   oCYCLE/oFETCH_CNT              - cycle and accepted-instruction counters
module fetch_sequencer
  import rv_fetch_defs::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                XLEN     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 32
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  output logic              oROM_CE,
  output logic              oROM_RD,
  output logic [ADDR_W-3:0] oROM_ADDR,
  input  logic [XLEN-1:0]   iROM_DATA,
  input  logic              iROM_VALID,
  output logic [XLEN-1:0]   oIR,
  output logic [ADDR_W-1:0] oIR_PC,
  output logic              oIR_VALID,
  input  logic              iIR_READY,
  input  logic              iBR_TAKEN,
  input  logic [ADDR_W-1:0] iBR_TARGET,
  output logic              oMISALIGN,
  output logic [CNT_W-1:0]  oCYCLE,
  output logic [CNT_W-1:0]  oFETCH_CNT
);

  fetch_state_t      state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [ADDR_W-3:0] addr_reg;
  logic [XLEN-1:0]   ir_reg, ir_next;
  logic [ADDR_W-1:0] ir_pc_reg, ir_pc_next;
  logic              misalign_reg, misalign_next;
  logic              accept;
  logic [ADDR_W-1:0] br_pc;

  // Redirect targets are forced to word alignment; the low bits only feed
  // the sticky misalign flag.
  assign br_pc = {iBR_TARGET[ADDR_W-1:2], 2'b00};

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_reg    <= ST_FETCH;
      pc_reg       <= RESET_PC;
      addr_reg     <= '0;
      ir_reg       <= '0;
      ir_pc_reg    <= '0;
      misalign_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      ir_reg       <= ir_next;
      ir_pc_reg    <= ir_pc_next;
      misalign_reg <= misalign_next;
      // Capture the issued address so WAIT/KILL keep presenting it even
      // after a redirect has already moved PC to the target.
      if (state_reg == ST_FETCH) begin
        addr_reg <= pc_reg[ADDR_W-1:2];
      end
    end
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    ir_next       = ir_reg;
    ir_pc_next    = ir_pc_reg;
    misalign_next = misalign_reg;
    accept        = 1'b0;

    if (iBR_TAKEN && (iBR_TARGET[1:0] != 2'b00)) begin
      misalign_next = 1'b1;
    end

    case (state_reg)
      ST_FETCH, ST_WAIT: begin
        if (iBR_TAKEN) begin
          pc_next    = br_pc;
          // A response arriving together with the redirect is simply
          // dropped; otherwise the in-flight access must drain first.
          state_next = iROM_VALID ? ST_FETCH : ST_KILL;
        end else if (iROM_VALID) begin
          ir_next    = iROM_DATA;
          ir_pc_next = pc_reg;
          state_next = ST_HOLD;
        end else begin
          state_next = ST_WAIT;
        end
      end
      ST_HOLD: begin
        accept = iIR_READY;
        if (iBR_TAKEN) begin
          pc_next    = br_pc;
          state_next = ST_FETCH;
        end else if (iIR_READY) begin
          pc_next    = pc_reg + ADDR_W'(ILEN_BYTES);
          state_next = ST_FETCH;
        end
      end
      ST_KILL: begin
        if (iBR_TAKEN) begin
          pc_next = br_pc;
        end
        if (iROM_VALID) begin
          state_next = ST_FETCH;
        end
      end
      default: state_next = ST_FETCH;
    endcase
  end

  assign oROM_CE   = (state_reg != ST_HOLD);
  assign oROM_RD   = oROM_CE;
  assign oROM_ADDR = (state_reg == ST_FETCH) ? pc_reg[ADDR_W-1:2] : addr_reg;
  assign oIR       = ir_reg;
  assign oIR_PC    = ir_pc_reg;
  assign oIR_VALID = (state_reg == ST_HOLD);
  assign oMISALIGN = misalign_reg;

  fetch_counters #(
    .CNT_W(CNT_W)
  ) u_counters (
    .clk       (iCLK),
    .rst_n     (iRST_N),
    .fetch_inc (accept),
    .cycle     (oCYCLE),
    .fetch_cnt (oFETCH_CNT)
  );

endmodule
